vdp_cpu_port: RTL and testbench

- CPU-facing access port of the video subsystem.
- Sits directly upstream of the VRAM dual-port RAM and drives its CPU-side port: address, write data, write enable and clock enable.
- Decodes TMS9918-style data and control port byte sequences into VDP register writes, VRAM writes and read-ahead prefetches, with address auto-increment.

---
 rtl/vdp_port_pkg.sv | 15 +
 rtl/vdp_cpu_port.sv | 189 ++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_port_pkg.sv
// Shared types and control-byte field positions for the VDP CPU access port.
package vdp_port_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_ISSUE   = 2'd1,
        RD_CAPTURE = 2'd2,
        WR_ISSUE   = 2'd3
    } state_e;

    localparam int CTRL_REG_BIT = 7;
    localparam int CTRL_WR_BIT  = 6;
    localparam int ADDR_HI_MSB  = 5;

endpackage

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU data/control port decoder driving the CPU side of the VRAM.
// Optional macro VDP_WRITE_FILLS_BUFFER_EN: a data write also refreshes the read-ahead buffer.
module vdp_cpu_port
    import vdp_port_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int REG_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_busy,
    input  logic [7:0]        status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [REG_W-1:0]  reg_num,
    output logic [7:0]        reg_data,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         buf_q, buf_d;
    logic [7:0]         latch_q, latch_d;
    logic               flag_q, flag_d;
    logic [7:0]         dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               status_rd_q, status_rd_d;
    logic               reg_we_q, reg_we_d;
    logic [REG_W-1:0]   reg_num_q, reg_num_d;
    logic [7:0]         reg_data_q, reg_data_d;
    logic               ram_ce_q, ram_ce_d;
    logic               ram_we_q, ram_we_d;
    logic [7:0]         wdata_q, wdata_d;

    logic               busy_s;
    logic               wr_s;
    logic               rd_s;
    logic [13:0]        setup_addr_s;

    assign busy_s       = (state_q != IDLE);
    assign wr_s         = cpu_wr;
    assign rd_s         = cpu_rd & ~cpu_wr;
    assign setup_addr_s = {cpu_din[ADDR_HI_MSB:0], latch_q};

    // Next-state, datapath and strobe decode; control setup is applied after the access sequencing so it wins over auto-increment
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        latch_d     = latch_q;
        flag_d      = flag_q;
        dout_d      = dout_q;
        status_rd_d = 1'b0;
        reg_we_d    = 1'b0;
        reg_num_d   = reg_num_q;
        reg_data_d  = reg_data_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RD_ISSUE: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                buf_d   = ram_rdata;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = IDLE;
            end
            WR_ISSUE: begin
`ifdef VDP_WRITE_FILLS_BUFFER_EN
                buf_d   = wdata_q;
`else
                buf_d   = buf_q;
`endif
                addr_d  = addr_q + ADDR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cpu_mode) begin
            if (wr_s) begin
                if (!flag_q) begin
                    latch_d = cpu_din;
                    flag_d  = 1'b1;
                end else begin
                    flag_d = 1'b0;
                    if (cpu_din[CTRL_REG_BIT]) begin
                        reg_we_d   = 1'b1;
                        reg_num_d  = cpu_din[REG_W-1:0];
                        reg_data_d = latch_q;
                    end else if (cpu_din[CTRL_WR_BIT]) begin
                        addr_d = ADDR_W'(setup_addr_s);
                    end else if (!busy_s) begin
                        addr_d  = ADDR_W'(setup_addr_s);
                        state_d = RD_ISSUE;
                    end else begin
                        // prefetch setup refused while an access is in flight
                        flag_d = 1'b0;
                    end
                end
            end else if (rd_s) begin
                dout_d      = status_in;
                status_rd_d = 1'b1;
                flag_d      = 1'b0;
            end else begin
                flag_d = flag_d;
            end
        end else if (!busy_s) begin
            if (wr_s) begin
                wdata_d = cpu_din;
                flag_d  = 1'b0;
                state_d = WR_ISSUE;
            end else if (rd_s) begin
                dout_d  = buf_q;
                flag_d  = 1'b0;
                state_d = RD_ISSUE;
            end else begin
                flag_d = flag_d;
            end
        end else begin
            flag_d = flag_d;
        end

        busy_d   = (state_d != IDLE);
        ram_ce_d = (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
        ram_we_d = (state_d == WR_ISSUE);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            buf_q       <= 8'h00;
            latch_q     <= 8'h00;
            flag_q      <= 1'b0;
            dout_q      <= 8'h00;
            busy_q      <= 1'b0;
            status_rd_q <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_num_q   <= '0;
            reg_data_q  <= 8'h00;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            wdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            latch_q     <= latch_d;
            flag_q      <= flag_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            status_rd_q <= status_rd_d;
            reg_we_q    <= reg_we_d;
            reg_num_q   <= reg_num_d;
            reg_data_q  <= reg_data_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cpu_dout  = dout_q;
    assign cpu_busy  = busy_q;
    assign status_rd = status_rd_q;
    assign reg_we    = reg_we_q;
    assign reg_num   = reg_num_q;
    assign reg_data  = reg_data_q;
    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a behavioural VRAM and a write-address log.
module tb_vdp_cpu_port;

    logic        clock;
    logic        reset_n;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_mode;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_busy;
    logic [7:0]  status_in;
    logic        status_rd;
    logic        reg_we;
    logic [2:0]  reg_num;
    logic [7:0]  reg_data;
    logic        ram_ce;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:16383];
    logic [13:0] wr_log [$];
    int          errors;
    int          checks;

    vdp_cpu_port #(.ADDR_W(14), .REG_W(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_mode  (cpu_mode),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_busy  (cpu_busy),
        .status_in (status_in),
        .status_rd (status_rd),
        .reg_we    (reg_we),
        .reg_num   (reg_num),
        .reg_data  (reg_data),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // VRAM model: synchronous write, read data one cycle after ram_ce
    always @(posedge clock) begin
        if (ram_ce) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_log.push_back(ram_addr);
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ctrl_wr(input logic [7:0] b);
        cpu_mode = 1'b1; cpu_din = b; cpu_wr = 1'b1;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic ctrl_rd();
        cpu_mode = 1'b1; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic data_wr(input logic [7:0] b);
        cpu_mode = 1'b0; cpu_din = b; cpu_wr = 1'b1;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic data_rd();
        cpu_mode = 1'b0; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", cpu_dout); end
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cpu_busy); end
        checks++; if ({ram_ce, ram_we, status_rd, reg_we} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {ram_ce, ram_we, status_rd, reg_we}); end
        checks++; if (ram_addr !== 14'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", ram_addr); end
        checks++; if ({reg_num, reg_data, ram_wdata} !== 19'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {reg_num, reg_data, ram_wdata}); end
    endtask

    task automatic test_data_write();
        ctrl_wr(8'h34);
        ctrl_wr(8'h52);
        checks++; if (ram_addr !== 14'h1234 || ram_ce !== 1'b0 || cpu_busy !== 1'b0) begin errors++; $display("FAIL wr_setup: got addr=%h ce=%b busy=%b want 1234/0/0", ram_addr, ram_ce, cpu_busy); end
        data_wr(8'hA5);
        checks++; if ({ram_ce, ram_we, cpu_busy} !== 3'b111) begin errors++; $display("FAIL wr_issue_ctl: got %b want 111", {ram_ce, ram_we, cpu_busy}); end
        checks++; if (ram_addr !== 14'h1234 || ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_issue_data: got %h/%h want 1234/a5", ram_addr, ram_wdata); end
        step();
        checks++; if (ram_ce !== 1'b0 || cpu_busy !== 1'b0 || ram_addr !== 14'h1235) begin errors++; $display("FAIL wr_done: got ce=%b busy=%b addr=%h want 0/0/1235", ram_ce, cpu_busy, ram_addr); end
        checks++; if (mem[14'h1234] !== 8'hA5) begin errors++; $display("FAIL wr_mem: got %h want a5", mem[14'h1234]); end
    endtask

    task automatic test_read_prefetch();
        ctrl_wr(8'h00);
        ctrl_wr(8'h41);
        data_wr(8'h11); step();
        data_wr(8'h22); step();
        ctrl_wr(8'h00);
        ctrl_wr(8'h01);
        checks++; if ({ram_ce, ram_we, cpu_busy} !== 3'b101 || ram_addr !== 14'h0100) begin errors++; $display("FAIL pf_issue: got ctl=%b addr=%h want 101/0100", {ram_ce, ram_we, cpu_busy}, ram_addr); end
        step();
        checks++; if (ram_ce !== 1'b0 || cpu_busy !== 1'b1) begin errors++; $display("FAIL pf_capture: got ce=%b busy=%b want 0/1", ram_ce, cpu_busy); end
        step();
        checks++; if (cpu_busy !== 1'b0 || ram_addr !== 14'h0101) begin errors++; $display("FAIL pf_done: got busy=%b addr=%h want 0/0101", cpu_busy, ram_addr); end
        data_rd();
        checks++; if (cpu_dout !== 8'h11) begin errors++; $display("FAIL rd1_dout: got %h want 11", cpu_dout); end
        step(); step();
        data_rd();
        checks++; if (cpu_dout !== 8'h22) begin errors++; $display("FAIL rd2_dout: got %h want 22", cpu_dout); end
        checks++; if (ram_addr !== 14'h0102 || ram_ce !== 1'b1) begin errors++; $display("FAIL rd2_addr: got %h ce=%b want 0102/1", ram_addr, ram_ce); end
        step(); step();
        checks++; if (ram_addr !== 14'h0103) begin errors++; $display("FAIL rd_end_addr: got %h want 0103", ram_addr); end
    endtask

    task automatic test_reg_write();
        ctrl_wr(8'hE1);
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reg_first: got %b want 0", reg_we); end
        ctrl_wr(8'h87);
        checks++; if (reg_we !== 1'b1 || reg_num !== 3'd7 || reg_data !== 8'hE1) begin errors++; $display("FAIL reg_pulse: got we=%b num=%0d data=%h want 1/7/e1", reg_we, reg_num, reg_data); end
        checks++; if (ram_ce !== 1'b0 || cpu_busy !== 1'b0 || ram_addr !== 14'h0103) begin errors++; $display("FAIL reg_noram: got ce=%b busy=%b addr=%h want 0/0/0103", ram_ce, cpu_busy, ram_addr); end
        step();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reg_oneshot: got %b want 0", reg_we); end
    endtask

    task automatic test_busy_ctrl();
        data_rd();
        ctrl_wr(8'h10);
        ctrl_wr(8'h00);
        checks++; if (ram_addr !== 14'h0104 || ram_ce !== 1'b0 || cpu_busy !== 1'b0) begin errors++; $display("FAIL busy_ignore: got addr=%h ce=%b busy=%b want 0104/0/0", ram_addr, ram_ce, cpu_busy); end
        ctrl_wr(8'h20);
        ctrl_wr(8'h40);
        checks++; if (ram_addr !== 14'h0020 || ram_ce !== 1'b0) begin errors++; $display("FAIL busy_flag_clr: got addr=%h ce=%b want 0020/0", ram_addr, ram_ce); end
    endtask

    task automatic test_status();
        ctrl_wr(8'h55);
        status_in = 8'h80;
        ctrl_rd();
        checks++; if (cpu_dout !== 8'h80 || status_rd !== 1'b1) begin errors++; $display("FAIL status_rd: got dout=%h pulse=%b want 80/1", cpu_dout, status_rd); end
        step();
        checks++; if (status_rd !== 1'b0) begin errors++; $display("FAIL status_oneshot: got %b want 0", status_rd); end
        ctrl_wr(8'h00);
        ctrl_wr(8'h00);
        checks++; if (ram_addr !== 14'h0000 || ram_ce !== 1'b1) begin errors++; $display("FAIL status_discard: got addr=%h ce=%b want 0000/1", ram_addr, ram_ce); end
        step(); step();
    endtask

    task automatic test_wrap();
        ctrl_wr(8'hFF);
        ctrl_wr(8'h7F);
        wr_log.delete();
        data_wr(8'h01);
        checks++; if (ram_addr !== 14'h3FFF || {ram_ce, ram_we} !== 2'b11) begin errors++; $display("FAIL wrap_w1: got addr=%h ctl=%b want 3fff/11", ram_addr, {ram_ce, ram_we}); end
        data_wr(8'h99);
        checks++; if (ram_addr !== 14'h0000 || ram_ce !== 1'b0 || ram_wdata !== 8'h01) begin errors++; $display("FAIL wrap_ignore: got addr=%h ce=%b wdata=%h want 0000/0/01", ram_addr, ram_ce, ram_wdata); end
        data_wr(8'h02);
        checks++; if (ram_addr !== 14'h0000 || {ram_ce, ram_we} !== 2'b11 || ram_wdata !== 8'h02) begin errors++; $display("FAIL wrap_w2: got addr=%h ctl=%b wdata=%h want 0000/11/02", ram_addr, {ram_ce, ram_we}, ram_wdata); end
        step();
        checks++; if (wr_log.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d writes want 2", wr_log.size()); end
        checks++; if (mem[14'h3FFF] !== 8'h01 || mem[14'h0000] !== 8'h02) begin errors++; $display("FAIL wrap_mem: got %h/%h want 01/02", mem[14'h3FFF], mem[14'h0000]); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp_buf;
        ctrl_wr(8'hFF);
        ctrl_wr(8'h3F);
        step(); step();
        ctrl_wr(8'h00);
        ctrl_wr(8'h02);
        checks++; if (ram_ce !== 1'b1 || ram_addr !== 14'h0200) begin errors++; $display("FAIL abort_pre: got ce=%b addr=%h want 1/0200", ram_ce, ram_addr); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (ram_ce !== 1'b0 || cpu_busy !== 1'b0 || ram_addr !== 14'h0000) begin errors++; $display("FAIL abort_state: got ce=%b busy=%b addr=%h want 0/0/0000", ram_ce, cpu_busy, ram_addr); end
        step();
        data_wr(8'h77);
        step();
        data_rd();
`ifdef VDP_WRITE_FILLS_BUFFER_EN
        exp_buf = 8'h77;
`else
        exp_buf = 8'h00;
`endif
        checks++; if (cpu_dout !== exp_buf) begin errors++; $display("FAIL abort_buffer: got %h want %h", cpu_dout, exp_buf); end
        step(); step();
    endtask

    initial begin
        errors = 0; checks = 0;
        reset_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_mode = 1'b0;
        cpu_din = 8'h00; status_in = 8'h00; ram_rdata = 8'h00;
        test_reset();
        test_data_write();
        test_read_prefetch();
        test_reg_write();
        test_busy_ctrl();
        test_status();
        test_wrap();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
